// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared channel state type, default timing constants and width helpers
package button_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        REPEATING  = 2'd2
    } chan_state_t;

    localparam int DEF_NUM_BTN      = 5;
    localparam int DEF_STABLE_TICKS = 4;
    localparam int DEF_REPEAT_DELAY = 25;
    localparam int DEF_REPEAT_RATE  = 5;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one debounced button with press one-shot and auto-repeat
module button_channel
    import button_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_repeat
);

    localparam int SW = cnt_width(STABLE_TICKS);
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic          raw_s1;
    logic          raw_s2;
    logic [SW-1:0] stab_cnt;
    logic [SW-1:0] stab_cnt_n;
    logic          flip;
    logic          level_n;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_cnt_n;
    logic          press_n;
    logic          repeat_n;
    chan_state_t   state;
    chan_state_t   state_n;

    // Bring the raw contact into the clk domain before any decision is made on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_s1 <= 1'b0;
            raw_s2 <= 1'b0;
        end else begin
            raw_s1 <= btn_raw;
            raw_s2 <= raw_s1;
        end
    end

    // Debounce: the level flips only after STABLE_TICKS consecutive disagreeing ticks.
    always_comb begin
        stab_cnt_n = stab_cnt;
        flip       = 1'b0;
        if (tick) begin
            if (raw_s2 != btn_level) begin
                if (stab_cnt == STAB_LAST) begin
                    flip       = 1'b1;
                    stab_cnt_n = '0;
                end else begin
                    stab_cnt_n = stab_cnt + SW'(1);
                end
            end else begin
                stab_cnt_n = '0;
            end
        end
    end

    assign level_n = btn_level ^ flip;

    // Press/repeat FSM; a release flip wins over any repeat falling due on the same tick.
    always_comb begin
        state_n   = state;
        rpt_cnt_n = rpt_cnt;
        press_n   = 1'b0;
        repeat_n  = 1'b0;
        if (tick) begin
            if (flip && !btn_level) begin
                press_n   = 1'b1;
                rpt_cnt_n = '0;
                state_n   = WAIT_DELAY;
            end else if (flip && btn_level) begin
                rpt_cnt_n = '0;
                state_n   = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        rpt_cnt_n = '0;
                    end
                    WAIT_DELAY: begin
                        if (rpt_cnt == DELAY_LAST) begin
                            repeat_n  = 1'b1;
                            rpt_cnt_n = '0;
                            state_n   = REPEATING;
                        end else begin
                            rpt_cnt_n = rpt_cnt + RW'(1);
                        end
                    end
                    REPEATING: begin
                        if (rpt_cnt == RATE_LAST) begin
                            repeat_n  = 1'b1;
                            rpt_cnt_n = '0;
                        end else begin
                            rpt_cnt_n = rpt_cnt + RW'(1);
                        end
                    end
                    default: begin
                        rpt_cnt_n = '0;
                        state_n   = IDLE;
                    end
                endcase
            end
        end
    end

    // Channel state and registered outputs; pulses last exactly one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt   <= '0;
            rpt_cnt    <= '0;
            state      <= IDLE;
            btn_level  <= 1'b0;
            btn_press  <= 1'b0;
            btn_repeat <= 1'b0;
        end else begin
            stab_cnt   <= stab_cnt_n;
            rpt_cnt    <= rpt_cnt_n;
            state      <= state_n;
            btn_level  <= level_n;
            btn_press  <= press_n;
            btn_repeat <= repeat_n;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - slow-tick edge detector feeding NUM_BTN debounced button channels
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN      = DEF_NUM_BTN,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_lvl,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic               tick
);

    logic s1;
    logic s2;
    logic s3;

    // The divided clock is only data here: synchronize it, keep one history bit,
    // and register the rising-edge strobe. A level already high at reset release
    // yields one tick, which is harmless to the debouncers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= tick_lvl;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    localparam int NB = 5;

    logic          clk;
    logic          rst;
    logic          tick_lvl;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_repeat;
    logic          tick;

    button_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .tick_lvl   (tick_lvl),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_repeat (btn_repeat),
        .tick       (tick)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int rise_n = 0;
    int tick_count = 0;
    bit gen_en = 0;
    bit chk_tick = 0;
    bit timed_out = 0;
    logic prev_tick = 0;
    logic [NB-1:0] prev_press = '0;
    logic [NB-1:0] prev_rep = '0;
    int press_cnt [NB] = '{default: 0};
    int press_tick[NB] = '{default: 0};
    int press_cyc [NB] = '{default: 0};
    int rep_cnt   [NB] = '{default: 0};
    int rep_tick  [NB] = '{default: 0};
    int t0;
    int p;
    int r;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // tick_lvl: 20-clk period square wave, changed on the falling edge
    initial begin
        tick_lvl = 0;
        wait (gen_en);
        forever begin
            repeat (10) @(negedge clk);
            tick_lvl = ~tick_lvl;
            if (tick_lvl) begin
                rise_cyc = cyc;
                rise_n++;
            end
        end
    end

    // Monitor: counts ticks and pulses, checks pulse width and exclusivity
    always @(negedge clk) begin
        if (tick) begin
            tick_count++;
            check_val("tick_width", prev_tick, 0);
            if (chk_tick) begin
                check_val("tick_delay", cyc - rise_cyc, 3);
                check_val("tick_per_edge", tick_count, rise_n);
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i]) begin
                press_cnt[i]++;
                press_tick[i] = tick_count;
                press_cyc[i]  = cyc;
                check_val("press_width", prev_press[i], 0);
                check_val("press_rep_excl", btn_repeat[i], 0);
            end
            if (btn_repeat[i]) begin
                rep_cnt[i]++;
                rep_tick[i] = tick_count;
                check_val("rep_width", prev_rep[i], 0);
            end
        end
        prev_tick  = tick;
        prev_press = btn_press;
        prev_rep   = btn_repeat;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        if (timed_out) return;
        do begin
            step();
            k++;
        end while (!tick && k < 60);
        if (!tick) begin
            check_val("tick_timeout", tick, 1);
            timed_out = 1;
        end
    endtask

    task automatic wait_until(input int n);
        while (tick_count < n && !timed_out) wait_tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        btn_raw = '0;
        repeat (3) step();
        check_val("rst_level", btn_level, 0);
        check_val("rst_press", btn_press, 0);
        check_val("rst_repeat", btn_repeat, 0);
        check_val("rst_tick", tick, 0);

        // Reset then idle
        rst = 0;
        gen_en = 1;
        chk_tick = 1;
        repeat (10) wait_tick();
        step();
        chk_tick = 0;
        check_val("idle_level", btn_level, 0);
        check_val("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4], 0);
        check_val("idle_repeat", rep_cnt[0] + rep_cnt[1] + rep_cnt[2] + rep_cnt[3] + rep_cnt[4], 0);

        // Clean press on channel 0
        t0 = tick_count;
        btn_raw[0] = 1;
        repeat (3) wait_tick();
        step();
        check_val("p0_early_level", btn_level[0], 0);
        wait_tick();
        step();
        check_val("p0_level", btn_level, 5'b00001);
        check_val("p0_cnt", press_cnt[0], 1);
        check_val("p0_tick", press_tick[0], t0 + 4);
        check_val("p0_others", press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4], 0);
        step();
        check_val("p0_pulse_gone", btn_press, 0);
        btn_raw[0] = 0;
        repeat (4) wait_tick();
        step();
        check_val("r0_level", btn_level[0], 0);
        check_val("r0_press", press_cnt[0], 1);
        check_val("r0_repeat", rep_cnt[0], 0);

        // Bounce rejection on channel 1
        for (int k = 0; k < 10; k++) begin
            btn_raw[1] = ~btn_raw[1];
            repeat (2) wait_tick();
        end
        check_val("b1_nopress", press_cnt[1], 0);
        check_val("b1_level", btn_level[1], 0);
        t0 = tick_count;
        btn_raw[1] = 1;
        repeat (4) wait_tick();
        step();
        check_val("b1_press", press_cnt[1], 1);
        check_val("b1_tick", press_tick[1], t0 + 4);
        btn_raw[1] = 0;
        repeat (4) wait_tick();
        step();
        check_val("b1_rel", btn_level[1], 0);

        // Auto-repeat on channel 2
        t0 = tick_count;
        p = t0 + 4;
        btn_raw[2] = 1;
        wait_until(p + 24);
        step();
        check_val("a2_before_first", rep_cnt[2], 0);
        wait_until(p + 25);
        step();
        check_val("a2_first_cnt", rep_cnt[2], 1);
        check_val("a2_first_tick", rep_tick[2], p + 25);
        wait_until(p + 30);
        step();
        check_val("a2_second_tick", rep_tick[2], p + 30);
        wait_until(p + 46);
        btn_raw[2] = 0;
        wait_until(p + 49);
        step();
        check_val("a2_level_held", btn_level[2], 1);
        wait_tick();
        step();
        check_val("a2_level_rel", btn_level[2], 0);
        check_val("a2_rep_total", rep_cnt[2], 5);
        check_val("a2_last_tick", rep_tick[2], p + 45);
        repeat (10) wait_tick();
        step();
        check_val("a2_quiet_rep", rep_cnt[2], 5);
        check_val("a2_quiet_press", press_cnt[2], 1);

        // Simultaneous press on 3 and 4, release of 3 on a due repeat
        t0 = tick_count;
        p = t0 + 4;
        btn_raw[4:3] = 2'b11;
        wait_until(p);
        step();
        check_val("s34_press3", press_cnt[3], 1);
        check_val("s34_press4", press_cnt[4], 1);
        check_val("s34_same_cyc", press_cyc[3], press_cyc[4]);
        check_val("s34_tick", press_tick[3], p);
        wait_until(p + 21);
        btn_raw[3] = 0;
        wait_until(p + 25);
        step();
        check_val("s3_level", btn_level[3], 0);
        check_val("s3_norepeat", rep_cnt[3], 0);
        check_val("s4_repeat", rep_cnt[4], 1);
        check_val("s4_rep_tick", rep_tick[4], p + 25);
        btn_raw[4] = 0;
        repeat (10) wait_tick();
        step();
        check_val("s3_idle_rep", rep_cnt[3], 0);
        check_val("s4_final_rep", rep_cnt[4], 1);
        check_val("s34_level", btn_level[4:3], 0);

        // Reset while channel 0 is repeating
        t0 = tick_count;
        p = t0 + 4;
        btn_raw[0] = 1;
        wait_until(p + 27);
        step();
        check_val("m0_repeating", rep_cnt[0], 1);
        check_val("m0_level", btn_level[0], 1);
        rst = 1;
        #1;
        check_val("m0_rst_level", btn_level, 0);
        check_val("m0_rst_press", btn_press, 0);
        check_val("m0_rst_repeat", btn_repeat, 0);
        repeat (3) step();
        rst = 0;
        r = tick_count;
        wait_until(r + 3);
        step();
        check_val("m0_requal_early", btn_level[0], 0);
        wait_until(r + 4);
        step();
        check_val("m0_new_press", press_cnt[0], 3);
        check_val("m0_new_press_tick", press_tick[0], r + 4);
        wait_until(r + 28);
        step();
        check_val("m0_no_early_rep", rep_cnt[0], 1);
        wait_until(r + 29);
        step();
        check_val("m0_new_rep", rep_cnt[0], 2);
        check_val("m0_new_rep_tick", rep_tick[0], r + 29);
        btn_raw[0] = 0;
        repeat (4) wait_tick();
        step();
        check_val("m0_final_level", btn_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
